// File: rtl/multiword_add_seq.sv
// Word-serial wide add/subtract sequencer around an N-bit adder stage.
// Define MWADD_SAT_EN to saturate the result on signed overflow.

module mwadd_stage #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [N:0] sum;

  assign sum  = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
  assign s    = sum[N-1:0];
  assign cout = sum[N];
  // carry into the MSB recovered from the MSB sum bit
  assign ovf  = (x[N-1] ^ y[N-1] ^ sum[N-1]) ^ sum[N];

endmodule

module multiword_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               sub,
  input  logic [N*WORDS-1:0] A,
  input  logic [N*WORDS-1:0] B,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               zero
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cy_q, cy_d;
  logic [W-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [N-1:0]  x_w;
  logic [N-1:0]  y_w;
  logic [N-1:0]  s_w;
  logic          cout_w;
  logic          ovf_w;
  logic [W-1:0]  res_w;
  logic [W-1:0]  fin_w;
  logic          last_w;

  assign x_w    = a_q[idx_q*N +: N];
  assign y_w    = b_q[idx_q*N +: N] ^ {N{sub_q}};
  assign last_w = (idx_q == IW'(WORDS - 1));

  mwadd_stage #(
    .N (N)
  ) u_stage (
    .x    (x_w),
    .y    (y_w),
    .cin  (cy_q),
    .s    (s_w),
    .cout (cout_w),
    .ovf  (ovf_w)
  );

  always_comb begin
    res_w = res_q;
    res_w[idx_q*N +: N] = s_w;
    fin_w = res_w;
`ifdef MWADD_SAT_EN
    if (ovf_w) begin
      fin_w = a_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                       : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = sub;
          idx_d   = '0;
          cy_d    = sub;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_w;
        cy_d  = cout_w;
        idx_d = idx_q + IW'(1);
        if (last_w) begin
          res_d   = fin_w;
          carry_d = cout_w;
          ovf_d   = ovf_w;
          zero_d  = (fin_w == '0);
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed plan cases plus random ops
// against an integer-arithmetic reference model.

module tb_multiword_add_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  int n_chk  = 0;
  int n_fail = 0;

  multiword_add_seq #(
    .N     (N),
    .WORDS (WORDS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: true signed/unsigned arithmetic on the full operands
  task automatic model(input  logic [W-1:0] a,
                       input  logic [W-1:0] b,
                       input  logic         s,
                       output logic [W-1:0] res,
                       output logic         cy,
                       output logic         ov);
    longint sa, sb, tv, ua, ub;
    longint lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({1'b0, a});
    ub  = longint'({1'b0, b});
    lim = longint'(1) << (W - 1);
    tv  = s ? sa - sb : sa + sb;
    ov  = (tv >= lim) || (tv < -lim);
    cy  = s ? (ua >= ub) : ((ua + ub) >= (lim << 1));
    res = W'(s ? ua - ub : ua + ub);
`ifdef MWADD_SAT_EN
    if (ov) res = (tv > 0) ? W'(lim - 1) : W'(lim);
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic         s);
    logic [W-1:0] er;
    logic ec, eo;
    int c;
    model(a, b, s, er, ec, eo);
    start = 1'b1;
    A = a;
    B = b;
    sub = s;
    tick();
    start = 1'b0;
    chk("busy_run", busy, 1);
    c = 0;
    while (c < WORDS + 4) begin
      tick();
      c++;
      if (done) break;
    end
    chk("latency", c, WORDS);
    chk("result", result, er);
    chk("carry", carry, ec);
    chk("overflow", overflow, eo);
    chk("zero", zero, er == '0);
    tick();
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("hold_result", result, er);
  endtask

  initial begin
    logic [W-1:0] er, er2;
    logic ec, eo;
    int dn;

    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 0);
    reset = 1'b0;
    tick();

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 6 == 0) rb = ra;
      if (i % 6 == 1) ra[W-1 -: 4] = 4'h7;
      run_op(ra, rb, 1'(i % 2));
    end

    // start held high, operands changed mid-RUN
    model(32'h1234_5678, 32'h1111_1111, 1'b0, er, ec, eo);
    model(32'hA0A0_A0A0, 32'h0505_0505, 1'b1, er2, ec, eo);
    start = 1'b1;
    A = 32'h1234_5678;
    B = 32'h1111_1111;
    sub = 1'b0;
    tick();
    dn = 0;
    for (int c = 1; c <= WORDS + 1; c++) begin
      tick();
      if (c == 1) begin
        A = 32'hA0A0_A0A0;
        B = 32'h0505_0505;
        sub = 1'b1;
      end
      if (done) begin
        dn++;
        chk("held_result", result, er);
      end
    end
    chk("held_done_cnt", dn, 1);
    chk("held_idle", busy, 0);
    tick();
    chk("held_restart", busy, 1);
    start = 1'b0;
    dn = 0;
    for (int c = 0; c < WORDS + 4 && dn == 0; c++) begin
      tick();
      if (done) dn++;
    end
    chk("second_done", dn, 1);
    chk("second_result", result, er2);
    tick();

    // reset sampled at edge k+2 aborts the operation
    start = 1'b1;
    A = 32'hFFFF_FFFF;
    B = 32'h0000_0002;
    sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry, 0);
    chk("abort_zero", zero, 0);
    dn = 0;
    for (int c = 0; c < WORDS + 3; c++) begin
      if (done) dn++;
      tick();
    end
    chk("abort_no_done", dn, 0);
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequencer that adds or subtracts two wide operands of WORDS×N bits.
- Feeds an N-bit combinational adder stage (X, Y, carryin → S, carryout, overflow) one word per cycle, least-significant word first.
- Consumes the adder's carryout and chains it into the next word's carryin.
- Registers the wide result and status flags, with a start/done handshake for the ALU control path.

Parameters:
N, 8, width of the adder stage in bits (one word)
WORDS, 4, number of words per operand; operand width W = N*WORDS

Ports:
clock  in  1  single system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
sub  in  1  0 = A+B, 1 = A−B (two's complement); sampled with start
A  in  W  operand A; sampled with start
B  in  W  operand B; sampled with start
busy  out  1  high while in RUN or DONE
done  out  1  one-cycle pulse: result and flags valid
result  out  W  registered sum/difference
carry  out  1  carry out of the most-significant word (for sub: 1 = no borrow)
overflow  out  1  signed overflow of the full W-bit operation
zero  out  1  result == 0

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, result=0, carry=0, overflow=0, zero=0. Word index and carry register are cleared.
- Reset mid-operation aborts immediately: no done pulse, outputs are zeroed.
- States: IDLE → RUN → DONE → IDLE.
- IDLE:
  - start=1 at edge k: latch A, B and sub; idx=0; carry register = sub; go to RUN.
  - start=0: stay in IDLE; outputs hold their last values.
- RUN: each edge processes word idx:
  - X = A word idx.
  - Y = B word idx, or its bitwise inverse when sub=1.
  - carryin = carry register.
  - S is written to result word idx; carry register = carryout; idx increments.
  - After word WORDS−1 (edge k+WORDS): capture the final carryout into carry and that word's adder overflow into overflow; compute zero from the full new result; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge.
  - Latency: start sampled at edge k → done high in the cycle after edge k+WORDS.
  - Throughput: one operation every WORDS+2 cycles.
- start while busy is ignored. It is not queued and latched operands are unaffected.
- Output hold and update rules:
  - result, carry, overflow and zero hold their values from DONE until the next operation's words are written.
  - Intermediate result words may change during RUN; they are valid only when done=1.
- Arithmetic is modulo 2^W.
  - overflow = carry into the MSB XOR carry out of the MSB, evaluated on the top word only.
  - Lower-word overflow outputs are ignored.
- WORDS=1 is legal: the block degenerates to a registered single add with a 1-cycle RUN.

Optional Feature:
- Macro: MWADD_SAT_EN.
- Defined: when the final overflow=1, the registered result saturates to the signed limit.
  - Positive overflow (A MSB=0 after Y inversion) → 0 followed by W−1 ones.
  - Negative overflow → 1 followed by W−1 zeros.
  - Saturation is applied in the DONE transition.
  - The overflow flag still reads 1.
  - zero is computed on the saturated value.
- Undefined: result is the wrapped modulo-2^W value; no saturation logic is present.

Test Plan (N=8, WORDS=4):
- A=0x000000FF, B=0x00000001, sub=0, start at edge k → done in the cycle after edge k+4; result=0x00000100, carry=0, overflow=0, zero=0.
- A=0xFFFFFFFF, B=0x00000001, sub=0 → result=0x00000000, carry=1, overflow=0, zero=1.
- A=0x7FFFFFFF, B=0x00000001, sub=0 → overflow=1. Without MWADD_SAT_EN: result=0x80000000. With MWADD_SAT_EN: result=0x7FFFFFFF.
- A=0x00000005, B=0x00000007, sub=1 → result=0xFFFFFFFE, carry=0 (borrow), overflow=0. Then A=0x80000000, B=0x00000001, sub=1 → overflow=1.
- start held high for the entire operation with A/B changed mid-RUN → exactly one done pulse; result reflects the originally latched operands; a second operation starts only from IDLE.
- reset asserted at edge k+2 of an operation → no done pulse; all outputs 0 at the next cycle; a new start is accepted normally afterwards.
